// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, in-order imem requests, response FIFO toward decode.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter int              XLEN            = 64,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_starve
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_req_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [31:0]     r_fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic            w_id_valid;
  logic            w_room;
  logic [CW-1:0]   w_out_next;
  logic [CW-1:0]   w_count_next;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_id_valid    = (r_count != '0);
  assign w_accept      = r_req_valid & imem_req_ready;
  assign w_push        = imem_rsp_valid & ~redirect_valid & (r_drop_cnt == '0);
  assign w_drop        = imem_rsp_valid & (redirect_valid | (r_drop_cnt != '0));
  assign w_pop         = w_id_valid & id_ready & ~redirect_valid;
  assign w_out_next    = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);
  assign w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);

  // Every in-flight request keeps a FIFO slot reserved, so responses never overflow.
  assign w_room = (w_out_next < CW'(MAX_OUTSTANDING)) &&
                  ((w_out_next + w_count_next) < CW'(FIFO_DEPTH));

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign id_valid       = w_id_valid;
  assign id_instr       = w_id_valid ? r_fifo_instr[r_rptr] : '0;
  assign id_pc          = w_id_valid ? r_fifo_pc[r_rptr]    : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_req_valid   <= 1'b0;
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_accept) begin
        r_pc <= r_pc + XLEN'(4);
      end
      if (redirect_valid) begin
        // Everything still owed by memory after this edge is stale.
        r_pc        <= w_redirect_pc;
        r_rsp_pc    <= w_redirect_pc;
        r_req_valid <= 1'b0;
        r_drop_cnt  <= w_out_next;
        r_state     <= (w_out_next != '0) ? ST_DRAIN : ST_RUN;
      end else begin
        r_req_valid <= (r_state == ST_RUN) && w_room;
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
        end
        if (imem_rsp_valid && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
          if (r_drop_cnt == CW'(1)) begin
            r_state <= ST_RUN;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wptr] <= imem_rsp_data;
      r_fifo_pc[r_wptr]    <= r_rsp_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;
  logic [31:0] r_perf_starve;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
      r_perf_starve  <= '0;
    end else begin
      r_perf_fetched <= r_perf_fetched + 32'(w_push);
      r_perf_dropped <= r_perf_dropped + 32'(w_drop);
      r_perf_starve  <= r_perf_starve + 32'(id_ready & ~w_id_valid);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
  assign perf_starve  = r_perf_starve;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(imem_rsp_valid && (r_outstanding == '0)))
        else $error("fetch_unit: response with no outstanding request");
      assert (!(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))))
        else $error("fetch_unit: push into full instruction buffer");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a stream-level model of expected fetch/decode PCs.
module tb_fetch_unit;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          MAXO     = 2;

  logic            clk;
  logic            reset_n;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_dropped;
  logic [31:0]     perf_starve;
`endif

  fetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(4), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped), .perf_starve(perf_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic [63:0] tgt;
    logic [63:0] exp_pc;
  } vec_t;

  req_t        memq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          outst = 0;
  int          max_outst = 0;
  int          n_acc = 0;
  int          n_id = 0;
  int          first_acc = -1;
  int          first_id = -1;
  logic [63:0] exp_req_pc;
  logic [63:0] exp_id_pc;
  bit          want_first = 0;
  logic [63:0] first_pc = 64'h0;
  bit          redir_pending = 0;
  int          rsp_since_redir = 0;
  int          drop_expect = 0;
  bit          last_redir_rsp = 0;
  bit          last_redir_pop = 0;
  bit          p_req_valid = 0, p_req_ready = 0, p_id_valid = 0, p_id_ready = 0, p_redir = 0;
  logic [63:0] p_req_addr = 64'h0, p_pc = 64'h0;
  logic [31:0] p_instr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; inputs driven and outputs sampled at the falling edge.
  task automatic step(input bit rdy, input bit idr, input bit redir, input logic [63:0] tgt);
    int cur;
    int d;
    bit rsp;
    bit acc;
    bit pop;
    @(negedge clk);
    cur = cyc;
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = redir;
    redirect_pc    = tgt;
    rsp = (memq.size() > 0) && (memq[0].due <= cur);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(memq[0].addr) : 32'hDEAD_BEEF;

    if (p_redir) begin
      chk("flush_id_valid", 64'(id_valid), 64'd0);
      chk("redirect_no_req", 64'(imem_req_valid), 64'd0);
    end else begin
      if (p_req_valid && !p_req_ready) begin
        chk("req_hold_valid", 64'(imem_req_valid), 64'd1);
        chk("req_hold_addr", imem_req_addr, p_req_addr);
      end
      if (p_id_valid && !p_id_ready) begin
        chk("id_hold_valid", 64'(id_valid), 64'd1);
        chk("id_hold_pc", id_pc, p_pc);
        chk("id_hold_instr", 64'(id_instr), 64'(p_instr));
      end
    end

    acc = imem_req_valid && rdy;
    pop = id_valid && idr && !redir;
    if (acc) begin
      chk("req_addr", imem_req_addr, exp_req_pc);
      if (redir_pending) begin
        chk("drain_before_issue", 64'(rsp_since_redir >= drop_expect), 64'd1);
        redir_pending = 0;
      end
      d = cur + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      memq.push_back('{addr: imem_req_addr, due: d});
      exp_req_pc = exp_req_pc + 64'd4;
      outst++;
      n_acc++;
      if (outst > max_outst) max_outst = outst;
      chk("outstanding_limit", 64'(outst <= MAXO), 64'd1);
      if (first_acc < 0) first_acc = cur;
    end
    if (rsp) begin
      void'(memq.pop_front());
      outst--;
      if (!redir) rsp_since_redir++;
    end
    if (pop) begin
      chk("id_pc", id_pc, exp_id_pc);
      chk("id_instr", 64'(id_instr), 64'(mem_word(exp_id_pc)));
      exp_id_pc = exp_id_pc + 64'd4;
      n_id++;
      if (first_id < 0) first_id = cur;
      if (want_first) begin
        first_pc   = id_pc;
        want_first = 0;
      end
    end
    if (redir) begin
      exp_req_pc      = tgt & ~64'h3;
      exp_id_pc       = tgt & ~64'h3;
      redir_pending   = 1;
      rsp_since_redir = 0;
      drop_expect     = outst;
      want_first      = 1;
      last_redir_rsp  = rsp;
      last_redir_pop  = id_valid && idr;
    end
    p_req_valid = imem_req_valid;
    p_req_ready = rdy;
    p_req_addr  = imem_req_addr;
    p_id_valid  = id_valid;
    p_id_ready  = idr;
    p_pc        = id_pc;
    p_instr     = id_instr;
    p_redir     = redir;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    memq.delete();
    outst = 0; max_outst = 0; n_acc = 0; n_id = 0; first_acc = -1; first_id = -1;
    exp_req_pc = RESET_PC; exp_id_pc = RESET_PC; last_due = cyc;
    p_req_valid = 0; p_req_ready = 0; p_id_valid = 0; p_id_ready = 0; p_redir = 0;
    redir_pending = 0; want_first = 1;
    cyc++;
    @(negedge clk);
    reset_n = 1'b1;
    chk("reset_req_valid", 64'(imem_req_valid), 64'd0);
    chk("reset_req_addr", imem_req_addr, RESET_PC);
    chk("reset_id_valid", 64'(id_valid), 64'd0);
    chk("reset_id_instr", 64'(id_instr), 64'd0);
    chk("reset_id_pc", id_pc, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("reset_perf_fetched", 64'(perf_fetched), 64'd0);
    chk("reset_perf_dropped", 64'(perf_dropped), 64'd0);
    chk("reset_perf_starve", 64'(perf_starve), 64'd0);
`endif
    cyc++;
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{tgt: 64'h0000_0000_0000_1003, exp_pc: 64'h0000_0000_0000_1000};
    vecs[1] = '{tgt: 64'h0000_0000_0000_0200, exp_pc: 64'h0000_0000_0000_0200};
    vecs[2] = '{tgt: 64'h0000_0000_0000_07FF, exp_pc: 64'h0000_0000_0000_07FC};
    vecs[3] = '{tgt: 64'hFFFF_FFFF_FFFF_FFFA, exp_pc: 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[4] = '{tgt: 64'hABCD_0001_2345_6789, exp_pc: 64'hABCD_0001_2345_6788};

    reset_n = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    exp_req_pc = RESET_PC; exp_id_pc = RESET_PC;

    // Streaming with 1-cycle memory.
    do_reset();
    lat = 1;
    repeat (30) step(1, 1, 0, 64'h0);
    chk("first_id_latency", 64'(first_id - first_acc), 64'd2);
    chk("first_id_pc", first_pc, 64'h0);
    chk("contiguous_stream", 64'(n_id), 64'(cyc - first_id));
    $display("stream: %0d instructions delivered, first at cycle %0d", n_id, first_id);

    // Decode stalled: buffer fills, request issue stops.
    do_reset();
    repeat (20) step(1, 0, 0, 64'h0);
    chk("stall_accepts", 64'(n_acc), 64'd4);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall_outstanding", 64'(outst), 64'd0);
    chk("stall_id_valid", 64'(id_valid), 64'd1);
    chk("stall_id_pc", id_pc, 64'h0);
    repeat (20) step(1, 1, 0, 64'h0);
    chk("stall_release", 64'(n_id >= 4), 64'd1);
    $display("stall: %0d accepted while stalled, %0d delivered after release", 4, n_id);

    // Long latency: outstanding limit.
    do_reset();
    lat = 5;
    repeat (60) step(1, 1, 0, 64'h0);
    chk("max_outstanding", 64'(max_outst), 64'(MAXO));
    chk("long_lat_progress", 64'(n_id >= 10), 64'd1);
    $display("latency5: max outstanding %0d, %0d delivered", max_outst, n_id);

    // Redirect with two requests in flight.
    do_reset();
    lat = 5;
    for (int k = 0; k < 20 && !(outst == 2 && memq[0].due > cyc); k++) step(1, 1, 0, 64'h0);
    chk("pre_redirect_outstanding", 64'(outst), 64'd2);
    step(1, 1, 1, 64'h1003);
    chk("redirect_drop_count", 64'(drop_expect), 64'd2);
    repeat (40) step(1, 1, 0, 64'h0);
    chk("refetch_started", 64'(redir_pending), 64'd0);
    chk("first_pc_after_redirect", first_pc, 64'h1000);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_dropped", 64'(perf_dropped), 64'd2);
`endif
    $display("redirect 0x1003: first id_pc 0x%0h", first_pc);

    // Redirect colliding with response and pop, then back-to-back redirect.
    do_reset();
    lat = 1;
    repeat (10) step(1, 1, 0, 64'h0);
    step(1, 1, 1, 64'h200);
    chk("collide_rsp", 64'(last_redir_rsp), 64'd1);
    chk("collide_pop", 64'(last_redir_pop), 64'd1);
    step(1, 1, 1, 64'h300);
    repeat (25) step(1, 1, 0, 64'h0);
    chk("back_to_back_pc", first_pc, 64'h300);
    $display("back-to-back redirect: first id_pc 0x%0h", first_pc);

    // Table of redirect targets.
    lat = 2;
    for (int v = 0; v < 5; v++) begin
      repeat (6) step(1, 1, 0, 64'h0);
      step(1, 1, 1, vecs[v].tgt);
      for (int k = 0; k < 40 && want_first; k++) step(1, 1, 0, 64'h0);
      chk("redirect_vec_timeout", 64'(want_first), 64'd0);
      chk("redirect_vec_pc", first_pc, vecs[v].exp_pc);
      $display("vector %0d: redirect 0x%0h -> first id_pc 0x%0h", v, vecs[v].tgt, first_pc);
      repeat (6) step(1, 1, 0, 64'h0);
    end

    // Reset in the middle of a stream.
    repeat (10) step(1, 1, 0, 64'h0);
    do_reset();
    repeat (20) step(1, 1, 0, 64'h0);
    chk("restart_pc", first_pc, RESET_PC);
    $display("mid-stream reset: restart id_pc 0x%0h", first_pc);

    // Random traffic against the stream model.
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) lat = $urandom_range(1, 6);
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 3, {$urandom, $urandom});
    end
    $display("random: %0d instructions delivered", n_id);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
